// File: rtl/button_pkg.sv
// Shared types and defaults for the button press generator.
package button_pkg;

    localparam int CW_DEF = 8;  // timer / hold / gap width
    localparam int PW_DEF = 3;  // pending-request counter width

    // Press sequencer states; 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        RELEASE = 2'd2
    } press_state_t;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter shared by the PRESS and RELEASE phases.
// Load has priority; otherwise the count decrements and parks at zero.
module cycle_timer #(
    parameter int CW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Load,
    input  logic [CW-1:0] LoadVal,
    output logic          Zero,
    output logic [CW-1:0] Count
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: load wins, else count down until zero.
    always_comb begin
        count_d = count_q;
        if (Load) begin
            count_d = LoadVal;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Zero  = (count_q == '0);
    assign Count = count_q;

endmodule

// File: rtl/button_press_gen.sv
// Turns one-cycle Go requests into timed button waveforms: Bo high for
// max(HoldCycles,1) cycles, then low for max(GapCycles,1) cycles.
// Requests arriving while busy are queued in a saturating counter and
// replayed back-to-back with no idle cycle in between.
// Handshake: Go is a fire-and-forget request, one per high cycle; there is
// no ready. A request that finds the queue full is dropped and flagged on
// the sticky Overflow, which only Reset clears.
module button_press_gen
    import button_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int PW = PW_DEF
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Go,
    input  logic [CW-1:0] HoldCycles,
    input  logic [CW-1:0] GapCycles,
    output logic          Bo,
    output logic          Busy,
    output logic          Done,
    output logic [PW-1:0] Pending,
    output logic          Overflow,
    output logic [1:0]    State
);

    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PEND_MAX = '1;

    press_state_t  state_q, state_d;
    logic          bo_q, bo_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [PW-1:0] pending_q, pending_d;
    logic          overflow_q, overflow_d;
    logic [CW-1:0] gap_q, gap_d;

    logic          tmr_load;
    logic [CW-1:0] tmr_load_val;
    logic          tmr_zero;
    logic [CW-1:0] tmr_count;

    logic [CW-1:0] hold_eff;
    logic [CW-1:0] gap_eff;
    logic          start;
    logic          consume;
    logic          go_queued;

    assign hold_eff = (HoldCycles == '0) ? ONE_C : HoldCycles;
    assign gap_eff  = (GapCycles  == '0) ? ONE_C : GapCycles;

    cycle_timer #(.CW(CW)) u_timer (
        .Clk     (Clk),
        .Reset   (Reset),
        .Load    (tmr_load),
        .LoadVal (tmr_load_val),
        .Zero    (tmr_zero),
        .Count   (tmr_count)
    );

    // Next-state, timer control, queue bookkeeping and registered outputs.
    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        pending_d    = pending_q;
        overflow_d   = overflow_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        start        = 1'b0;
        consume      = 1'b0;
        go_queued    = 1'b0;

        case (state_q)
            IDLE: begin
                if (Go) begin
                    state_d = PRESS;
                    start   = 1'b1;
                end
            end
            PRESS: begin
                if (tmr_zero) begin
                    state_d      = RELEASE;
                    tmr_load     = 1'b1;
                    tmr_load_val = gap_q - 1'b1;
                end
            end
            RELEASE: begin
                if (tmr_zero) begin
                    if ((pending_q != '0) || Go) begin
                        // Chain straight into the next press, no IDLE gap.
                        state_d = PRESS;
                        start   = 1'b1;
                        consume = (pending_q != '0);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Lengths are captured only on the edge that enters PRESS.
        if (start) begin
            tmr_load     = 1'b1;
            tmr_load_val = hold_eff - 1'b1;
            gap_d        = gap_eff;
        end

        // A Go that directly starts a press with an empty queue is not queued.
        if ((state_q == PRESS) || (state_q == RELEASE)) begin
            go_queued = Go && !(start && !consume);
        end

        if (consume && go_queued) begin
            pending_d = pending_q;
        end else if (consume) begin
            pending_d = pending_q - 1'b1;
        end else if (go_queued) begin
            if (pending_q == PEND_MAX) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + 1'b1;
            end
        end

        if (state_d == IDLE) begin
            pending_d = '0;
        end

        bo_d   = (state_d == PRESS);
        busy_d = (state_d != IDLE);
        // Done marks the cycle whose timer value will be zero in RELEASE.
        done_d = (state_d == RELEASE) &&
                 (tmr_load ? (tmr_load_val == '0) : (tmr_count == ONE_C));
    end

    // State and output registers; reset drops Bo without waiting for a clock.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            bo_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            gap_q      <= ONE_C;
        end else begin
            state_q    <= state_d;
            bo_q       <= bo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            gap_q      <= gap_d;
        end
    end

    assign Bo       = bo_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Pending  = pending_q;
    assign Overflow = overflow_q;
    assign State    = state_q;

endmodule
